// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Takes the execute-stage wb_* registers and drives the
//   register-file write port. Load data returned by data memory is lane-aligned
//   and sign/zero-extended here. While a load response is outstanding the stage
//   holds execute/fetch through stall_read. Misaligned loads, bad funct3 codes
//   and loads that time out raise a one-cycle load_err. instret counts retired
//   (completed, non-killed, error-free) instructions.
//
// Ports
//   clk, reset            clock / async active-low reset
//   wb_*                  execute-stage results for the instruction in this slot
//   dmem_rvalid/rdata     load response (word-aligned data)
//   stall_read            combinational hold request to execute and fetch
//   reg_we/waddr/wdata    registered register-file write port
//   load_err              registered one-cycle error pulse
//   instret               retired-instruction counter (wraps)
module writeback_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          wb_result,
  input  logic                 wb_alu_to_reg,
  input  logic                 wb_mem_to_reg,
  input  logic                 wb_mem_write,
  input  logic [4:0]           wb_dest_reg_sel,
  input  logic [1:0]           wb_read_address,
  input  logic [2:0]           wb_alu_operation,
  input  logic                 wb_kill,
  input  logic                 dmem_rvalid,
  input  logic [31:0]          dmem_rdata,
  output logic                 stall_read,
  output logic                 reg_we,
  output logic [4:0]           reg_waddr,
  output logic [31:0]          reg_wdata,
  output logic                 load_err,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int         TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [0:0]           state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 reg_we_q, reg_we_d;
  logic [4:0]           reg_waddr_q, reg_waddr_d;
  logic [31:0]          reg_wdata_q, reg_wdata_d;
  logic                 load_err_q, load_err_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic        is_load, ld_bad, complete, timed_out, stall_c, timeout_hit;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  // Lane extraction from the word-aligned response.
  assign byte_v = dmem_rdata[{wb_read_address, 3'b000} +: 8];
  assign half_v = dmem_rdata[{wb_read_address[1], 4'b0000} +: 16];

  // The issue cycle in IDLE counts as the first waiting cycle, so the load is
  // abandoned in the WAIT cycle where the incremented count reaches
  // TIMEOUT_CYCLES-1 (stall_read is high for TIMEOUT_CYCLES-1 cycles in total).
  assign timeout_hit = (int'(cnt_q) + 1) >= (TIMEOUT_CYCLES - 1);

  always_comb begin
    is_load   = wb_mem_to_reg & ~wb_kill;
    ld_bad    = 1'b0;
    load_data = dmem_rdata;
    unique case (wb_alu_operation)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'b0, byte_v};
      3'b001: begin
        load_data = {{16{half_v[15]}}, half_v};
        ld_bad    = wb_read_address[0];
      end
      3'b101: begin
        load_data = {16'b0, half_v};
        ld_bad    = wb_read_address[0];
      end
      3'b010: begin
        load_data = dmem_rdata;
        ld_bad    = (wb_read_address != 2'b00);
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Sequencing: decide whether the slot completes, waits or times out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    timed_out = 1'b0;
    stall_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!wb_kill) begin
          // Faulty loads never reach memory-wait; they retire as errors now.
          if (is_load && !ld_bad && !dmem_rvalid) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            stall_c = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      default: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d   = cnt_q + TW'(1);
          stall_c = 1'b1;
        end
      end
    endcase
  end

  // Completion effects, visible on the next cycle's outputs.
  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    load_err_d  = timed_out;
    instret_d   = instret_q;
    if (complete) begin
      if (is_load && ld_bad) begin
        load_err_d = 1'b1;
      end else begin
        instret_d = instret_q + CNT_WIDTH'(1);
        if (wb_alu_to_reg && (wb_dest_reg_sel != 5'd0)) begin
          reg_we_d    = 1'b1;
          reg_waddr_d = wb_dest_reg_sel;
          reg_wdata_d = is_load ? load_data : wb_result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      load_err_q  <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      load_err_q  <= load_err_d;
      instret_q   <= instret_d;
    end
  end

  // Stores need no write-port action; they only retire, which the
  // completion path already counts.
  logic unused_mem_write;
  assign unused_mem_write = wb_mem_write;

  assign stall_read = stall_c & reset;
  assign reg_we     = reg_we_q;
  assign reg_waddr  = reg_waddr_q;
  assign reg_wdata  = reg_wdata_q;
  assign load_err   = load_err_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int T  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   wb_result;
  logic          wb_alu_to_reg, wb_mem_to_reg, wb_mem_write;
  logic [4:0]    wb_dest_reg_sel;
  logic [1:0]    wb_read_address;
  logic [2:0]    wb_alu_operation;
  logic          wb_kill, dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic          stall_read, reg_we, load_err;
  logic [4:0]    reg_waddr;
  logic [31:0]   reg_wdata;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  writeback_stage #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .wb_result(wb_result), .wb_alu_to_reg(wb_alu_to_reg), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_mem_write(wb_mem_write), .wb_dest_reg_sel(wb_dest_reg_sel),
    .wb_read_address(wb_read_address), .wb_alu_operation(wb_alu_operation),
    .wb_kill(wb_kill), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_read(stall_read), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .load_err(load_err), .instret(instret)
  );

  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;
  int st_cnt;

  // Reference model state: what the outputs must be this cycle.
  bit          e_stall, e_we, e_err;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  int          e_instret;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_read", 32'(stall_read), 32'(e_stall));
      check("reg_we",     32'(reg_we),     32'(e_we));
      check("reg_waddr",  32'(reg_waddr),  32'(e_waddr));
      check("reg_wdata",  reg_wdata,       e_wdata);
      check("load_err",   32'(load_err),   32'(e_err));
      check("instret",    32'(instret),    32'(e_instret % (1 << CW)));
    end
  end

  function automatic bit is_bad(input logic [2:0] f3, input int off);
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2 == 1)) return 1'b1;
    if (f3 == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input int off, input logic [31:0] d);
    longint w;
    int b, h;
    w = longint'(d);
    b = int'((w >> (8 * off)) % 256);
    h = int'((w >> (8 * off)) % 65536);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return d;
    endcase
  endfunction

  // Presents one instruction, holds it while the pipeline is stalled, and
  // advances the model. lat = cycle (from presentation) in which rvalid rises.
  task automatic run_instr(input logic [31:0] res, input bit a2r, input bit m2r, input bit mw,
                           input logic [4:0] rd, input logic [1:0] off, input logic [2:0] f3,
                           input bit kill, input int lat, input logic [31:0] data);
    bit ld, bad;
    int last;
    ld   = m2r && !kill;
    bad  = ld && is_bad(f3, int'(off));
    last = (ld && !bad) ? ((lat < T - 1) ? lat : T - 1) : 0;
    wb_result = res; wb_alu_to_reg = a2r; wb_mem_to_reg = m2r; wb_mem_write = mw;
    wb_dest_reg_sel = rd; wb_read_address = off; wb_alu_operation = f3;
    wb_kill = kill; dmem_rdata = data;
    st_cnt = 0;
    for (int i = 0; i <= last; i++) begin
      dmem_rvalid = ld ? (i == lat) : 1'($urandom_range(0, 1));
      e_stall = (i < last);
      #3;
      if (stall_read) st_cnt++;
      @(posedge clk);
      #1;
      e_we  = 1'b0;
      e_err = 1'b0;
      if (i == last && !kill) begin
        if (bad || (ld && lat > last)) begin
          e_err = 1'b1;
        end else begin
          e_instret++;
          if (a2r && rd != 0) begin
            e_we    = 1'b1;
            e_waddr = rd;
            e_wdata = ld ? load_value(f3, int'(off), data) : res;
          end
        end
      end
    end
  endtask

  task automatic rand_instr();
    logic [31:0] res, data;
    bit a2r, m2r, mw, kill;
    logic [4:0] rd;
    logic [1:0] off;
    logic [2:0] f3;
    int lat, r;
    res  = $urandom(); data = $urandom();
    m2r  = ($urandom_range(0, 99) < 45);
    kill = ($urandom_range(0, 99) < 12);
    a2r  = m2r ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
    mw   = !m2r && !a2r && 1'($urandom_range(0, 1));
    rd   = 5'($urandom_range(0, 31));
    r    = $urandom_range(0, 9);
    case ($urandom_range(0, 5))
      0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; 4: f3 = 3'd5;
      default: f3 = 3'($urandom_range(0, 7));
    endcase
    off = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) begin
      if (f3 == 3'd2) off = 2'd0;
      else if (f3 == 3'd1 || f3 == 3'd5) off[0] = 1'b0;
    end
    if (r < 5)       lat = 0;
    else if (r < 8)  lat = $urandom_range(1, T - 1);
    else if (r == 8) lat = T - 1;
    else             lat = T + 6;
    run_instr(res, a2r, m2r, mw, rd, off, f3, kill, lat, data);
  endtask

  task automatic model_reset();
    e_stall = 1'b0; e_we = 1'b0; e_err = 1'b0;
    e_waddr = '0; e_wdata = '0; e_instret = 0;
  endtask

  task automatic idle_inputs();
    wb_result = '0; wb_alu_to_reg = 1'b0; wb_mem_to_reg = 1'b0; wb_mem_write = 1'b0;
    wb_dest_reg_sel = '0; wb_read_address = '0; wb_alu_operation = '0;
    wb_kill = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    // A pending load on the inputs must not stall while reset is held.
    wb_mem_to_reg = 1'b1;
    wb_alu_operation = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall_read", 32'(stall_read), 32'd0);
    check("rst reg_we",     32'(reg_we),     32'd0);
    check("rst reg_waddr",  32'(reg_waddr),  32'd0);
    check("rst reg_wdata",  reg_wdata,       32'd0);
    check("rst load_err",   32'(load_err),   32'd0);
    check("rst instret",    32'(instret),    32'd0);
    idle_inputs();
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Directed cases with hand-computed values.
    run_instr(32'h1234_5678, 1, 0, 0, 5'd5, 2'd0, 3'd0, 0, 0, 32'h0);
    check("lit alu we",    32'(reg_we),    32'd1);
    check("lit alu waddr", 32'(reg_waddr), 32'd5);
    check("lit alu wdata", reg_wdata,      32'h1234_5678);
    check("lit alu instret", 32'(instret), 32'd1);
    run_instr(32'h0, 1, 1, 0, 5'd6, 2'd3, 3'd0, 0, 0, 32'h80FF_0000);
    check("lit lb stall", 32'(st_cnt), 32'd0);
    check("lit lb wdata", reg_wdata, 32'hFFFF_FF80);
    run_instr(32'h0, 1, 1, 0, 5'd6, 2'd3, 3'd4, 0, 0, 32'h80FF_0000);
    check("lit lbu wdata", reg_wdata, 32'h0000_0080);
    run_instr(32'h0, 1, 1, 0, 5'd7, 2'd0, 3'd2, 0, 3, 32'hDEAD_BEEF);
    check("lit lw stalls", 32'(st_cnt), 32'd3);
    check("lit lw wdata",  reg_wdata,   32'hDEAD_BEEF);
    run_instr(32'h0, 1, 1, 0, 5'd8, 2'd1, 3'd1, 0, 0, 32'h1111_2222);
    check("lit lh mis stalls",  32'(st_cnt),   32'd0);
    check("lit lh mis err",     32'(load_err), 32'd1);
    check("lit lh mis we",      32'(reg_we),   32'd0);
    check("lit lh mis instret", 32'(instret),  32'd4);
    run_instr(32'h0, 1, 1, 0, 5'd9, 2'd0, 3'd2, 0, 99, 32'h0);
    check("lit tmo stalls",  32'(st_cnt),   32'd3);
    check("lit tmo err",     32'(load_err), 32'd1);
    check("lit tmo we",      32'(reg_we),   32'd0);
    check("lit tmo instret", 32'(instret),  32'd4);
    run_instr(32'hCAFE_0000, 1, 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 32'h0);
    check("lit x0 we",      32'(reg_we),  32'd0);
    check("lit x0 instret", 32'(instret), 32'd5);
    run_instr(32'hCAFE_0001, 1, 0, 0, 5'd3, 2'd0, 3'd0, 1, 0, 32'h0);
    check("lit kill we",      32'(reg_we),  32'd0);
    check("lit kill instret", 32'(instret), 32'd5);

    // Randomized traffic; enough retirements to wrap the counter.
    for (int n = 0; n < 500; n++) rand_instr();

    // Reset while a load is waiting.
    chk_en = 1'b0;
    wb_mem_to_reg = 1'b1; wb_alu_to_reg = 1'b1; wb_kill = 1'b0;
    wb_alu_operation = 3'd2; wb_read_address = 2'd0; dmem_rvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("wait stall", 32'(stall_read), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst stall_read", 32'(stall_read), 32'd0);
    check("midrst reg_we",     32'(reg_we),     32'd0);
    check("midrst reg_waddr",  32'(reg_waddr),  32'd0);
    check("midrst reg_wdata",  reg_wdata,       32'd0);
    check("midrst load_err",   32'(load_err),   32'd0);
    check("midrst instret",    32'(instret),    32'd0);
    idle_inputs();
    model_reset();
    #1 reset = 1'b1;
    chk_en = 1'b1;
    for (int n = 0; n < 40; n++) rand_instr();
    run_instr(32'h0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
